// File: rtl/id_decode_stage.sv
// RV32I instruction decode stage: decodes one instruction per handshake into
// a single registered control/operand bundle with valid/ready flow control.
module id_decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] inst,
  input  logic [31:0] pc_in,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] pc_out,
  output logic [4:0]  alu_op,
  output logic [31:0] imm,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        alu_src_b,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic        jump,
  output logic        illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [4:0] ALU_NOP   = 5'b00000;
  localparam logic [4:0] ALU_LUI   = 5'b00001;
  localparam logic [4:0] ALU_AUIPC = 5'b00010;
  localparam logic [4:0] ALU_ADD   = 5'b00011;
  localparam logic [4:0] ALU_SUB   = 5'b00100;
  localparam logic [4:0] ALU_BNE   = 5'b00101;
  localparam logic [4:0] ALU_BLT   = 5'b00110;
  localparam logic [4:0] ALU_BGE   = 5'b00111;
  localparam logic [4:0] ALU_BLTU  = 5'b01000;
  localparam logic [4:0] ALU_BGEU  = 5'b01001;
  localparam logic [4:0] ALU_SLT   = 5'b01010;
  localparam logic [4:0] ALU_SLTU  = 5'b01011;
  localparam logic [4:0] ALU_XOR   = 5'b01100;
  localparam logic [4:0] ALU_OR    = 5'b01101;
  localparam logic [4:0] ALU_AND   = 5'b01110;
  localparam logic [4:0] ALU_SLL   = 5'b01111;
  localparam logic [4:0] ALU_SRL   = 5'b10000;
  localparam logic [4:0] ALU_SRA   = 5'b10001;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_sh = {27'b0, inst[24:20]};

  logic [4:0]  alu_d;
  logic [31:0] imm_d;
  logic        src_d, wen_d, mr_d, mw_d, br_d, jp_d, legal_d;

  // Instruction decode; any unrecognised encoding collapses to an all-zero illegal bundle.
  always_comb begin
    alu_d   = ALU_NOP;
    imm_d   = '0;
    src_d   = 1'b0;
    wen_d   = 1'b0;
    mr_d    = 1'b0;
    mw_d    = 1'b0;
    br_d    = 1'b0;
    jp_d    = 1'b0;
    legal_d = 1'b1;
    case (opcode)
      OPC_LUI: begin
        alu_d = ALU_LUI; imm_d = imm_u; src_d = 1'b1; wen_d = 1'b1;
      end
      OPC_AUIPC: begin
        alu_d = ALU_AUIPC; imm_d = imm_u; src_d = 1'b1; wen_d = 1'b1;
      end
      OPC_JAL: begin
        alu_d = ALU_ADD; imm_d = imm_j; jp_d = 1'b1; wen_d = 1'b1;
      end
      OPC_JALR: begin
        alu_d = ALU_ADD; imm_d = imm_i; src_d = 1'b1; jp_d = 1'b1; wen_d = 1'b1;
        if (funct3 != 3'b000) legal_d = 1'b0;
      end
      OPC_BRANCH: begin
        // BEQ uses SUB so that Zero=1 means equal, i.e. taken.
        imm_d = imm_b; br_d = 1'b1;
        case (funct3)
          3'b000:  alu_d = ALU_SUB;
          3'b001:  alu_d = ALU_BNE;
          3'b100:  alu_d = ALU_BLT;
          3'b101:  alu_d = ALU_BGE;
          3'b110:  alu_d = ALU_BLTU;
          3'b111:  alu_d = ALU_BGEU;
          default: legal_d = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        alu_d = ALU_ADD; imm_d = imm_i; src_d = 1'b1; mr_d = 1'b1; wen_d = 1'b1;
        if (funct3 == 3'b011 || funct3[2:1] == 2'b11) legal_d = 1'b0;
      end
      OPC_STORE: begin
        alu_d = ALU_ADD; imm_d = imm_s; src_d = 1'b1; mw_d = 1'b1;
        if (funct3[2] || funct3 == 3'b011) legal_d = 1'b0;
      end
      OPC_OPIMM: begin
        imm_d = imm_i; src_d = 1'b1; wen_d = 1'b1;
        case (funct3)
          3'b000: alu_d = ALU_ADD;
          3'b010: alu_d = ALU_SLT;
          3'b011: alu_d = ALU_SLTU;
          3'b100: alu_d = ALU_XOR;
          3'b110: alu_d = ALU_OR;
          3'b111: alu_d = ALU_AND;
          3'b001: begin
            alu_d = ALU_SLL; imm_d = imm_sh;
            if (funct7 != F7_BASE) legal_d = 1'b0;
          end
          default: begin
            imm_d = imm_sh;
            if (funct7 == F7_BASE)     alu_d = ALU_SRL;
            else if (funct7 == F7_ALT) alu_d = ALU_SRA;
            else                       legal_d = 1'b0;
          end
        endcase
      end
      OPC_OP: begin
        wen_d = 1'b1;
        case ({funct7, funct3})
          {F7_BASE, 3'b000}: alu_d = ALU_ADD;
          {F7_ALT,  3'b000}: alu_d = ALU_SUB;
          {F7_BASE, 3'b001}: alu_d = ALU_SLL;
          {F7_BASE, 3'b010}: alu_d = ALU_SLT;
          {F7_BASE, 3'b011}: alu_d = ALU_SLTU;
          {F7_BASE, 3'b100}: alu_d = ALU_XOR;
          {F7_BASE, 3'b101}: alu_d = ALU_SRL;
          {F7_ALT,  3'b101}: alu_d = ALU_SRA;
          {F7_BASE, 3'b110}: alu_d = ALU_OR;
          {F7_BASE, 3'b111}: alu_d = ALU_AND;
          default:           legal_d = 1'b0;
        endcase
      end
      default: legal_d = 1'b0;
    endcase
    if (!legal_d) begin
      alu_d = ALU_NOP;
      imm_d = '0;
      src_d = 1'b0;
      wen_d = 1'b0;
      mr_d  = 1'b0;
      mw_d  = 1'b0;
      br_d  = 1'b0;
      jp_d  = 1'b0;
    end
  end

  logic        valid_q, src_q, rw_q, mr_q, mw_q, br_q, jp_q, ill_q;
  logic [31:0] pc_q, imm_q;
  logic [4:0]  alu_q, rs1_q, rs2_q, rd_q;
  logic        capture;

  assign in_ready = !valid_q || out_ready;
  assign capture  = in_valid && in_ready;

  // Output pipeline register; flush kills both the held and the incoming bundle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      alu_q   <= ALU_NOP;
      imm_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      src_q   <= 1'b0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      br_q    <= 1'b0;
      jp_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q <= 1'b1;
      pc_q    <= pc_in;
      alu_q   <= alu_d;
      imm_q   <= imm_d;
      rs1_q   <= inst[19:15];
      rs2_q   <= inst[24:20];
      rd_q    <= inst[11:7];
      src_q   <= src_d;
      rw_q    <= wen_d && (inst[11:7] != 5'd0);
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      br_q    <= br_d;
      jp_q    <= jp_d;
      ill_q   <= !legal_d;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign pc_out    = pc_q;
  assign alu_op    = alu_q;
  assign imm       = imm_q;
  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign rd        = rd_q;
  assign alu_src_b = src_q;
  assign reg_write = rw_q;
  assign mem_read  = mr_q;
  assign mem_write = mw_q;
  assign branch    = br_q;
  assign jump      = jp_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_id_decode_stage.sv
// Scoreboard bench for id_decode_stage: mnemonic-level reference model,
// directed handshake/flush/reset scenarios and randomized traffic.
module tb_id_decode_stage;

  logic        clk, rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] inst, pc_in, pc_out, imm;
  logic [4:0]  alu_op, rs1, rs2, rd;
  logic        alu_src_b, reg_write, mem_read, mem_write, branch, jump, illegal;

  id_decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .pc_in(pc_in), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .pc_out(pc_out), .alu_op(alu_op), .imm(imm),
    .rs1(rs1), .rs2(rs2), .rd(rd), .alu_src_b(alu_src_b),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .jump(jump), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {
    M_ILL, M_NOP, M_LUI, M_AUIPC, M_JAL, M_JALR,
    M_BEQ, M_BNE, M_BLT, M_BGE, M_BLTU, M_BGEU,
    M_LB, M_LH, M_LW, M_LBU, M_LHU, M_SB, M_SH, M_SW,
    M_ADDI, M_SLTI, M_SLTIU, M_XORI, M_ORI, M_ANDI, M_SLLI, M_SRLI, M_SRAI,
    M_ADD, M_SUB, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_SRA, M_OR, M_AND
  } mn_e;

  typedef enum int { F_N, F_R, F_I, F_S, F_B, F_U, F_J, F_H } fmt_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  alu, rs1, rs2, rd;
    logic        src, rw, mr, mw, br, jp, ill;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic mn_e mnem(input logic [31:0] w);
    logic [2:0] f3;
    logic [6:0] f7;
    mn_e n;
    f3 = w[14:12];
    f7 = w[31:25];
    n  = M_ILL;
    case (w[6:0])
      7'h37: n = M_LUI;
      7'h17: n = M_AUIPC;
      7'h6f: n = M_JAL;
      7'h67: if (f3 == 3'd0) n = M_JALR;
      7'h63: case (f3)
        3'd0: n = M_BEQ;  3'd1: n = M_BNE;  3'd4: n = M_BLT;
        3'd5: n = M_BGE;  3'd6: n = M_BLTU; 3'd7: n = M_BGEU;
        default: n = M_ILL;
      endcase
      7'h03: case (f3)
        3'd0: n = M_LB; 3'd1: n = M_LH; 3'd2: n = M_LW; 3'd4: n = M_LBU; 3'd5: n = M_LHU;
        default: n = M_ILL;
      endcase
      7'h23: case (f3)
        3'd0: n = M_SB; 3'd1: n = M_SH; 3'd2: n = M_SW;
        default: n = M_ILL;
      endcase
      7'h13: case (f3)
        3'd0: n = M_ADDI; 3'd2: n = M_SLTI; 3'd3: n = M_SLTIU;
        3'd4: n = M_XORI; 3'd6: n = M_ORI;  3'd7: n = M_ANDI;
        3'd1: n = (f7 == 7'h00) ? M_SLLI : M_ILL;
        default: n = (f7 == 7'h00) ? M_SRLI : (f7 == 7'h20) ? M_SRAI : M_ILL;
      endcase
      7'h33: begin
        if (f7 == 7'h00) begin
          case (f3)
            3'd0: n = M_ADD; 3'd1: n = M_SLL; 3'd2: n = M_SLT; 3'd3: n = M_SLTU;
            3'd4: n = M_XOR; 3'd5: n = M_SRL; 3'd6: n = M_OR;  default: n = M_AND;
          endcase
        end else if (f7 == 7'h20) begin
          if (f3 == 3'd0)      n = M_SUB;
          else if (f3 == 3'd5) n = M_SRA;
        end
      end
      default: n = M_ILL;
    endcase
    return n;
  endfunction

  function automatic logic [4:0] code_of(input mn_e b);
    case (b)
      M_LUI:  return 5'd1;  M_AUIPC: return 5'd2;  M_ADD:  return 5'd3;
      M_SUB:  return 5'd4;  M_BNE:   return 5'd5;  M_BLT:  return 5'd6;
      M_BGE:  return 5'd7;  M_BLTU:  return 5'd8;  M_BGEU: return 5'd9;
      M_SLT:  return 5'd10; M_SLTU:  return 5'd11; M_XOR:  return 5'd12;
      M_OR:   return 5'd13; M_AND:   return 5'd14; M_SLL:  return 5'd15;
      M_SRL:  return 5'd16; M_SRA:   return 5'd17;
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [31:0] imm_of(input fmt_e f, input logic [31:0] w);
    case (f)
      F_I: return 32'($signed(w[31:20]));
      F_S: return 32'($signed({w[31:25], w[11:7]}));
      F_B: return 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
      F_U: return {w[31:12], 12'b0};
      F_J: return 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
      F_H: return 32'(w[24:20]);
      default: return 32'd0;
    endcase
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    mn_e  n, b;
    fmt_e f;
    logic src, rw, mr, mw, br, jp;
    n = mnem(w);
    b = M_NOP; f = F_N;
    src = 0; rw = 0; mr = 0; mw = 0; br = 0; jp = 0;
    case (n)
      M_LUI, M_AUIPC: begin b = n; f = F_U; src = 1; rw = 1; end
      M_JAL:  begin b = M_ADD; f = F_J; jp = 1; rw = 1; end
      M_JALR: begin b = M_ADD; f = F_I; src = 1; jp = 1; rw = 1; end
      M_BEQ:  begin b = M_SUB; f = F_B; br = 1; end
      M_BNE, M_BLT, M_BGE, M_BLTU, M_BGEU: begin b = n; f = F_B; br = 1; end
      M_LB, M_LH, M_LW, M_LBU, M_LHU: begin b = M_ADD; f = F_I; src = 1; mr = 1; rw = 1; end
      M_SB, M_SH, M_SW: begin b = M_ADD; f = F_S; src = 1; mw = 1; end
      M_ADDI:  begin b = M_ADD;  f = F_I; src = 1; rw = 1; end
      M_SLTI:  begin b = M_SLT;  f = F_I; src = 1; rw = 1; end
      M_SLTIU: begin b = M_SLTU; f = F_I; src = 1; rw = 1; end
      M_XORI:  begin b = M_XOR;  f = F_I; src = 1; rw = 1; end
      M_ORI:   begin b = M_OR;   f = F_I; src = 1; rw = 1; end
      M_ANDI:  begin b = M_AND;  f = F_I; src = 1; rw = 1; end
      M_SLLI:  begin b = M_SLL;  f = F_H; src = 1; rw = 1; end
      M_SRLI:  begin b = M_SRL;  f = F_H; src = 1; rw = 1; end
      M_SRAI:  begin b = M_SRA;  f = F_H; src = 1; rw = 1; end
      M_ILL:   begin b = M_NOP;  f = F_N; end
      default: begin b = n;      f = F_R; rw = 1; end
    endcase
    e.pc  = pc;
    e.imm = imm_of(f, w);
    e.alu = code_of(b);
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    e.rd  = w[11:7];
    e.src = src;
    e.rw  = rw && (w[11:7] != 5'd0);
    e.mr  = mr;
    e.mw  = mw;
    e.br  = br;
    e.jp  = jp;
    e.ill = (n == M_ILL);
    return e;
  endfunction

  // Monitor: compares the presented bundle with the scoreboard head each cycle.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_alu_op", 32'(alu_op), 32'd0);
      chk("rst_pc_out", pc_out, 32'd0);
      chk("rst_imm", imm, 32'd0);
      chk("rst_flags", 32'({alu_src_b, reg_write, mem_read, mem_write, branch, jump, illegal}), 32'd0);
      sb_q.delete();
    end else begin
      logic exp_ready;
      exp_ready = (sb_q.size() == 0) || out_ready;
      chk("in_ready", 32'(in_ready), 32'(exp_ready));
      chk("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
      if (sb_q.size() != 0 && out_valid) begin
        exp_t e;
        e = sb_q[0];
        chk("pc_out", pc_out, e.pc);
        chk("alu_op", 32'(alu_op), 32'(e.alu));
        chk("imm", imm, e.imm);
        chk("rs1", 32'(rs1), 32'(e.rs1));
        chk("rs2", 32'(rs2), 32'(e.rs2));
        chk("rd", 32'(rd), 32'(e.rd));
        chk("alu_src_b", 32'(alu_src_b), 32'(e.src));
        chk("reg_write", 32'(reg_write), 32'(e.rw));
        chk("mem_read", 32'(mem_read), 32'(e.mr));
        chk("mem_write", 32'(mem_write), 32'(e.mw));
        chk("branch", 32'(branch), 32'(e.br));
        chk("jump", 32'(jump), 32'(e.jp));
        chk("illegal", 32'(illegal), 32'(e.ill));
      end
      if (sb_q.size() != 0 && (out_ready || flush)) void'(sb_q.pop_front());
      if (in_valid && exp_ready && !flush) sb_q.push_back(ref_decode(inst, pc_in));
    end
  end

  function automatic logic [31:0] rand_inst();
    logic [6:0]  opc, f7;
    logic [31:0] w;
    case ($urandom_range(0, 10))
      0: opc = 7'h37;  1: opc = 7'h17;  2: opc = 7'h6f;  3: opc = 7'h67;
      4: opc = 7'h63;  5: opc = 7'h03;  6: opc = 7'h23;  7: opc = 7'h13;
      8: opc = 7'h33;  9: opc = 7'($urandom);
      default: opc = 7'h73;
    endcase
    case ($urandom_range(0, 2))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    w = $urandom;
    w[31:25] = f7;
    w[6:0]   = opc;
    if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  // Presents one instruction at posedge+1, returns one cycle later with in_valid low.
  task automatic send(input logic [31:0] w);
    in_valid = 1'b1;
    inst     = w;
    pc_in    = $urandom;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; inst = '0; pc_in = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    send(32'hFFD08293);
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_alu", 32'(alu_op), 32'h03);
    chk("addi_imm", imm, 32'hFFFFFFFD);
    chk("addi_rd", 32'(rd), 32'd5);
    chk("addi_src", 32'(alu_src_b), 32'd1);
    chk("addi_rw", 32'(reg_write), 32'd1);

    send(32'h00209463);
    chk("bne_alu", 32'(alu_op), 32'h05);
    chk("bne_imm", imm, 32'h00000008);
    chk("bne_branch", 32'(branch), 32'd1);
    chk("bne_rw", 32'(reg_write), 32'd0);
    chk("bne_src", 32'(alu_src_b), 32'd0);

    send(32'h4041D193);
    chk("srai_alu", 32'(alu_op), 32'h11);
    chk("srai_imm", imm, 32'h00000004);

    send(32'h40419193);
    chk("slli_bad_ill", 32'(illegal), 32'd1);
    chk("slli_bad_alu", 32'(alu_op), 32'h00);

    // Stall for three cycles, then release with a new instruction waiting.
    send(32'h00C58533);
    out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b1; inst = 32'h002081B3; pc_in = 32'h1000; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("nobubble_valid", 32'(out_valid), 32'd1);
    chk("nobubble_pc", pc_out, 32'h1000);

    // Flush over a held bundle and a simultaneous incoming instruction.
    out_ready = 1'b0;
    in_valid = 1'b1; inst = 32'h00100093; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);

    // Asynchronous reset while stalled.
    out_ready = 1'b1;
    send(32'hFFD08293);
    out_ready = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", 32'(out_valid), 32'd0);
    chk("rst_async_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    send(32'hFFD08293);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_alu", 32'(alu_op), 32'h03);

    repeat (3000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      inst      = rand_inst();
      pc_in     = $urandom;
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 15) == 0);
      @(posedge clk); #1;
    end

    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
